// File: rtl/lsu_ctrl.sv
// Load/store unit: bridges core load/store requests to a word-addressed data
// memory. Sub-word stores are done as read-modify-write because the memory
// only writes whole words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// RD    | memory read issued, read word registered at end of cycle
// WR    | single-cycle memory write (SW data or merged SB/SH word)
// RESP  | response held until the core takes it with rsp_ready
module lsu_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign,
    output logic              rsp_illegal,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    // Width of the word index inside the memory; bits above it pass through.
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              misalign_q;
    logic              illegal_q;

    logic              accept;
    logic              req_illegal;
    logic              req_misalign;
    logic              req_fault;

    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    // Unsupported funct3 depends on direction: stores only have B/H/W.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                    f3 == F3_BU || f3 == F3_HU);
        end
        return bad;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Request decode; illegal masks misalign so only one flag is ever reported.
    always_comb begin
        req_illegal  = funct3_illegal(req_we, req_funct3);
        req_misalign = !req_illegal && addr_misaligned(req_funct3, req_addr[1:0]);
        req_fault    = req_illegal | req_misalign;
        accept       = req_valid && (state == IDLE) && !rst;
    end

    // Next-state selection for the request sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_nxt = RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and request capture; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q       <= req_we;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                misalign_q <= req_misalign;
                illegal_q  <= req_illegal;
            end
            if (state == RD) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Word address: index bits plus untouched upper bits, shifted down by two.
    always_comb begin
        word_addr = {2'b00, addr_q[ADDR_W-1:IDX_W+2], addr_q[IDX_W+1:2]};
    end

    // Select the addressed byte and halfword lanes of the registered read word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = rdata_q[7:0];
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            default: lane_byte = rdata_q[31:24];
        endcase
        lane_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    // Sign/zero extension of the selected lane for loads.
    always_comb begin
        case (funct3_q)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0, lane_half};
            F3_W:    load_data = rdata_q;
            default: load_data = 32'h0;
        endcase
    end

    // Store word: merge new byte/half into the word read in RD, or full SW data.
    always_comb begin
        store_word = rdata_q;
        case (funct3_q)
            F3_B: begin
                case (addr_q[1:0])
                    2'd0:    store_word[7:0]   = wdata_q[7:0];
                    2'd1:    store_word[15:8]  = wdata_q[7:0];
                    2'd2:    store_word[23:16] = wdata_q[7:0];
                    default: store_word[31:24] = wdata_q[7:0];
                endcase
            end
            F3_H: begin
                if (addr_q[1]) begin
                    store_word[31:16] = wdata_q[15:0];
                end else begin
                    store_word[15:0] = wdata_q[15:0];
                end
            end
            default: store_word = wdata_q;
        endcase
    end

    // Output drive; rst forces everything quiet, including a WR in progress.
    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_misalign = 1'b0;
        rsp_illegal  = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = 1'b1;
                RD:   mem_addr  = word_addr;
                WR: begin
                    mem_we    = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = store_word;
                end
                default: begin
                    rsp_valid    = 1'b1;
                    rsp_misalign = misalign_q;
                    rsp_illegal  = illegal_q;
                    if (!we_q && !misalign_q && !illegal_q) begin
                        rsp_rdata = load_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_illegal;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];
    logic        do_preload;
    int          we_pulses;
    logic [31:0] last_we_addr;
    logic [31:0] last_we_data;

    lsu_ctrl #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .rsp_illegal  (rsp_illegal),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];

    // Memory model: preload word 5 on request, otherwise write when mem_we.
    always @(posedge clk) begin
        if (do_preload) begin
            mem[5] <= 32'h8899AABB;
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        if (mem_we) begin
            we_pulses    <= we_pulses + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
    end

    task automatic preload();
        do_preload = 1'b1;
        @(posedge clk); #1;
        do_preload = 1'b0;
    endtask

    // Issue one request, measure edges from accept to rsp_valid, then consume.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic mis, output logic ill, output int pulses);
        int p0;
        int guard;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        p0         = we_pulses;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        mis   = rsp_misalign;
        ill   = rsp_illegal;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        pulses = we_pulses - p0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_misalign, rsp_illegal, mem_we, req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {rsp_valid, rsp_misalign, rsp_illegal, mem_we, req_ready});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd; logic mis, ill; int p;
        logic [31:0] addrs [5] = '{32'h15, 32'h15, 32'h16, 32'h14, 32'h14};
        logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b101, 3'b010, 3'b001};
        logic [31:0] exp   [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'h00008899,
                                   32'h8899AABB, 32'hFFFFAABB};
        preload();
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, f3s[i], addrs[i], 32'h0, lat, rd, mis, ill, p);
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("FAIL load_data[%0d]: got %h required %h", i, rd, exp[i]);
            end
            checks++;
            if (lat != 2 || mis !== 1'b0 || ill !== 1'b0 || p != 0) begin
                errors++;
                $display("FAIL load_lat_flags[%0d]: lat=%0d mis=%b ill=%b we=%0d required 2 0 0 0",
                         i, lat, mis, ill, p);
            end
        end
    endtask

    task automatic test_stores();
        int lat; logic [31:0] rd; logic mis, ill; int p;
        preload();
        run_op(1'b1, 3'b000, 32'h16, 32'h00000123, lat, rd, mis, ill, p);
        checks++;
        if (lat != 3 || rd !== 32'h0 || p != 1) begin
            errors++;
            $display("FAIL sb_resp: lat=%0d rdata=%h we=%0d required 3 0 1", lat, rd, p);
        end
        checks++;
        if (last_we_addr !== 32'h5 || last_we_data !== 32'h8823AABB) begin
            errors++;
            $display("FAIL sb_write: addr=%h data=%h required 00000005 8823aabb",
                     last_we_addr, last_we_data);
        end
        run_op(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, mis, ill, p);
        checks++;
        if (rd !== 32'h8823AABB) begin
            errors++;
            $display("FAIL sb_readback: got %h required 8823aabb", rd);
        end
        preload();
        run_op(1'b1, 3'b001, 32'h14, 32'h00005566, lat, rd, mis, ill, p);
        checks++;
        if (lat != 3 || p != 1 || mem[5] !== 32'h88995566) begin
            errors++;
            $display("FAIL sh_low: lat=%0d we=%0d word=%h required 3 1 88995566", lat, p, mem[5]);
        end
        run_op(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, lat, rd, mis, ill, p);
        checks++;
        if (lat != 2 || p != 1 || rd !== 32'h0 || mem[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw: lat=%0d we=%0d rdata=%h word=%h required 2 1 0 deadbeef",
                     lat, p, rd, mem[5]);
        end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic mis, ill; int p;
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] addrs [4] = '{32'h13, 32'h16, 32'h14, 32'h13};
        logic        emis  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        eill  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        preload();
        for (int i = 0; i < 4; i++) begin
            run_op(wes[i], f3s[i], addrs[i], 32'hFFFFFFFF, lat, rd, mis, ill, p);
            checks++;
            if (mis !== emis[i] || ill !== eill[i]) begin
                errors++;
                $display("FAIL fault_flags[%0d]: mis=%b ill=%b required %b %b",
                         i, mis, ill, emis[i], eill[i]);
            end
            checks++;
            if (lat != 1 || rd !== 32'h0 || p != 0) begin
                errors++;
                $display("FAIL fault_lat[%0d]: lat=%0d rdata=%h we=%0d required 1 0 0",
                         i, lat, rd, p);
            end
        end
        checks++;
        if (mem[5] !== 32'h8899AABB) begin
            errors++;
            $display("FAIL fault_mem: word5=%h required 8899aabb", mem[5]);
        end
    endtask

    task automatic test_addr_passthrough();
        int lat; logic [31:0] rd; logic mis, ill; int p;
        preload();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h80001014; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_addr !== 32'h20000405 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_addr: addr=%h we=%b required 20000405 0", mem_addr, mem_we);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8899AABB || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL passthrough_resp: valid=%b rdata=%h addr=%h required 1 8899aabb 0",
                     rsp_valid, rsp_rdata, mem_addr);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_op(1'b0, 3'b000, 32'h14, 32'h0, lat, rd, mis, ill, p);
        checks++;
        if (rd !== 32'hFFFFFFBB) begin
            errors++;
            $display("FAIL lb_lane0: got %h required ffffffbb", rd);
        end
    endtask

    task automatic test_back_pressure();
        preload();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h14; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8899AABB || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b rdata=%h ready=%b required 1 8899aabb 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        int p0;
        preload();
        p0 = we_pulses;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h14; req_wdata = 32'h0000FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h8899FFFF) begin
            errors++;
            $display("FAIL mid_wr_state: we=%b wdata=%h required 1 8899ffff", mem_we, mem_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_misalign, rsp_illegal, mem_we, req_ready} !== 5'b0 ||
            {rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL mid_rst_outputs: ctrl=%b rdata=%h addr=%h wdata=%h required all 0",
                     {rsp_valid, rsp_misalign, rsp_illegal, mem_we, req_ready},
                     rsp_rdata, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (mem[5] !== 32'h8899AABB || we_pulses != p0) begin
            errors++;
            $display("FAIL mid_rst_mem: word5=%h writes=%0d required 8899aabb 0",
                     mem[5], we_pulses - p0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        do_preload = 1'b0;
        we_pulses  = 0;
        last_we_addr = 32'h0;
        last_we_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_addr_passthrough();
        test_back_pressure();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
